// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc
//   Syndrome stage of the RS(255,249) decoder. It takes one GF(2^8) symbol
//   per accepted beat and uses Horner's rule to compute S_j = r(alpha^j)
//   for j = 1..6, with alpha = 8'h02 and field polynomial 0x11D.
//   The first symbol of a codeword is the coefficient of x^(N_SYM-1).
//
// Ports
//   clk        clock; all state changes on posedge
//   rst_n      asynchronous, active-low reset
//   in_valid   in_data holds a symbol this cycle
//   in_sop     marks the first symbol of a codeword (qualified by in_valid)
//   in_data    received symbol
//   in_ready   a symbol is accepted when in_valid & in_ready
//   w1..w6     syndromes S1..S6; held until the next codeword completes
//   signal     one-cycle pulse: w1..w6 are newly valid
//   nonzero    updated with signal; set when any syndrome is non-zero
//   frame_err  one-cycle pulse: in_sop arrived mid-codeword (restart)
//
// State table
//   state | meaning
//   IDLE  | waiting for an in_sop beat; beats without sop are dropped
//   ACCUM | Horner accumulation of the codeword in progress
//   DONE  | one dead cycle with signal high; input stalled

module multiply (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] a_sh;
    logic [7:0] acc;

    // Shift-and-add product. Reduction by x^8 = x^4+x^3+x^2+1 (0x11D).
    always_comb begin
        acc  = 8'h00;
        a_sh = a_i;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) acc = acc ^ a_sh;
            a_sh = {a_sh[6:0], 1'b0} ^ (a_sh[7] ? 8'h1D : 8'h00);
        end
        p_o = acc;
    end
endmodule

module rs_syndrome_calc #(
    parameter int N_SYM = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic       signal,
    output logic       nonzero,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t     state_q;
    logic [7:0] count_q;
    logic [7:0] acc_q [6];
    logic [7:0] w_q   [6];
    logic       signal_q;
    logic       nonzero_q;
    logic       frame_err_q;

    logic [7:0] prod     [6];
    logic [7:0] horner_d [6];
    logic       nonzero_d;
    logic       accept;
    logic       last_beat;

    assign in_ready  = (state_q != DONE);
    assign accept    = in_valid & in_ready;
    assign last_beat = (count_q == 8'(N_SYM - 1));

    // alpha^(j+1) = 1 << (j+1) for j = 0..5; no reduction is needed.
    for (genvar j = 0; j < 6; j++) begin : g_syn
        localparam logic [7:0] ALPHA_J = 8'(1 << (j + 1));
        multiply u_mul (
            .a_i (acc_q[j]),
            .b_i (ALPHA_J),
            .p_o (prod[j])
        );
        assign horner_d[j] = prod[j] ^ in_data;
    end

    always_comb begin
        nonzero_d = 1'b0;
        for (int j = 0; j < 6; j++) nonzero_d = nonzero_d | (|horner_d[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            signal_q    <= 1'b0;
            nonzero_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int j = 0; j < 6; j++) begin
                acc_q[j] <= 8'h00;
                w_q[j]   <= 8'h00;
            end
        end else begin
            signal_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && in_sop) begin
                        for (int j = 0; j < 6; j++) acc_q[j] <= in_data;
                        count_q <= 8'd1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_sop) begin
                            frame_err_q <= 1'b1;
                            for (int j = 0; j < 6; j++) acc_q[j] <= in_data;
                            count_q <= 8'd1;
                        end else if (last_beat) begin
                            // The final Horner step goes straight to the outputs,
                            // so signal and w1..w6 become valid on the same edge.
                            w_q       <= horner_d;
                            signal_q  <= 1'b1;
                            nonzero_q <= nonzero_d;
                            count_q   <= 8'd0;
                            state_q   <= DONE;
                        end else begin
                            acc_q   <= horner_d;
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w1        = w_q[0];
    assign w2        = w_q[1];
    assign w3        = w_q[2];
    assign w4        = w_q[3];
    assign w5        = w_q[4];
    assign w6        = w_q[5];
    assign signal    = signal_q;
    assign nonzero   = nonzero_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
module tb_rs_syndrome_calc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] w1, w2, w3, w4, w5, w6;
    logic       signal, nonzero, frame_err;

    int tests = 0;
    int fails = 0;
    int sig_cnt = 0;
    int fe_cnt = 0;
    int s0, f0;

    rs_syndrome_calc #(.N_SYM(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .w4        (w4),
        .w5        (w5),
        .w6        (w6),
        .signal    (signal),
        .nonzero   (nonzero),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (signal === 1'b1) sig_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4,
                         input logic [7:0] e5, input logic [7:0] e6);
        chk({tag, " w1"}, 32'(w1), 32'(e1));
        chk({tag, " w2"}, 32'(w2), 32'(e2));
        chk({tag, " w3"}, 32'(w3), 32'(e3));
        chk({tag, " w4"}, 32'(w4), 32'(e4));
        chk({tag, " w5"}, 32'(w5), 32'(e5));
        chk({tag, " w6"}, 32'(w6), 32'(e6));
    endtask

    // Present one symbol at a negedge; it is accepted on the next posedge.
    task automatic beat(input logic [7:0] d, input logic sop);
        int b = 0;
        while (in_ready !== 1'b1 && b < 10) begin
            @(negedge clk);
            b++;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $error("FAIL in_ready_timeout observed=%0b expected=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_data  = 8'h00;
    endtask

    // Send nbeats symbols; symbol at x^1 is v1 and at x^0 is v0 (for a full word).
    task automatic send_cw(input logic [7:0] v1, input logic [7:0] v0,
                           input int max_gap, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            beat((i == 253) ? v1 : (i == 254) ? v0 : 8'h00, i == 0);
            if (max_gap > 0 && i < nbeats - 1)
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    // Called at the negedge right after the last beat was accepted.
    task automatic done_check(input string tag, input logic nz);
        chk({tag, " signal"}, 32'(signal), 32'd1);
        chk({tag, " nonzero"}, 32'(nonzero), 32'(nz));
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, " signal_drop"}, 32'(signal), 32'd0);
        chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        void'($urandom(32'd7));
        repeat (2) @(negedge clk);
        chk_w("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset signal", 32'(signal), 32'd0);
        chk("reset nonzero", 32'(nonzero), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all-zero codeword
        s0 = sig_cnt;
        send_cw(8'h00, 8'h00, 0, 255);
        done_check("t1", 1'b0);
        chk_w("t1", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t1 sig_cnt", 32'(sig_cnt - s0), 32'd1);

        // 2: 01 at x^0
        send_cw(8'h00, 8'h01, 0, 255);
        done_check("t2", 1'b1);
        chk_w("t2", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);

        // Dropped beat in IDLE: no effect on outputs or flags
        s0 = sig_cnt; f0 = fe_cnt;
        beat(8'h5A, 1'b0);
        @(negedge clk);
        chk_w("drop", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        chk("drop sig", 32'(sig_cnt - s0), 32'd0);
        chk("drop fe", 32'(fe_cnt - f0), 32'd0);

        // 3: 01 at x^1
        send_cw(8'h01, 8'h00, 0, 255);
        done_check("t3", 1'b1);
        chk_w("t3", 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);

        // Mixed: r = 03*x + 05
        send_cw(8'h03, 8'h05, 0, 255);
        done_check("mix", 1'b1);
        chk_w("mix", 8'h03, 8'h09, 8'h1D, 8'h35, 8'h65, 8'hC5);

        // 4: test 3 with random gaps
        s0 = sig_cnt;
        send_cw(8'h01, 8'h00, 5, 255);
        done_check("t4", 1'b1);
        chk_w("t4", 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
        repeat (5) @(negedge clk);
        chk("t4 sig_cnt", 32'(sig_cnt - s0), 32'd1);

        // 5: restart at beat 100, then full codeword of test 2
        s0 = sig_cnt; f0 = fe_cnt;
        send_cw(8'h00, 8'h00, 0, 100);
        chk_w("t5 partial", 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
        send_cw(8'h00, 8'h01, 0, 254);
        chk("t5 no_early_sig", 32'(sig_cnt - s0), 32'd0);
        chk_w("t5 held", 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
        beat(8'h01, 1'b0);
        done_check("t5", 1'b1);
        chk_w("t5", 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        chk("t5 fe_cnt", 32'(fe_cnt - f0), 32'd1);
        chk("t5 sig_cnt", 32'(sig_cnt - s0), 32'd1);

        // 6: reset at beat 50, then test 3 codeword
        send_cw(8'h00, 8'h00, 0, 50);
        s0 = sig_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk_w("t6 rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t6 rst in_ready", 32'(in_ready), 32'd1);
        chk("t6 rst nonzero", 32'(nonzero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_cw(8'h01, 8'h00, 0, 255);
        done_check("t6", 1'b1);
        chk_w("t6", 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
        chk("t6 sig_cnt", 32'(sig_cnt - s0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
